// File: rtl/decode_instruction.sv
// decode_instruction: decode and register-read stage feeding execute.
// Splits the fetched word into fields and reads rA/rB from a 32x32 register
// file that has write-back bypass. It detects the one-cycle result-use hazard
// against the bundle now in execute, and registers the bundle for execute.
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   v_i, inst_i, pc_i    fetched instruction, valid and PC
//   stall_i, stall_o     stall from execute / combinational stall to fetch
//   branch_i             taken branch from execute, flushes this stage
//   wb_i, wb_r_i, wb_data_i  register write-back port from execute
//   v_o, pc_o, opecode_o, opr0_o, opr1_o, immf_o, immsign_o, imm_o,
//   stf_o, wb_o, wb_r_o  registered instruction bundle to execute
module decode_instruction #(
    parameter int unsigned ADDR   = 32,
    parameter int unsigned W_INST = 32,
    parameter int unsigned W_OPC  = 7,
    parameter int unsigned W_OPR  = 32,
    parameter int unsigned W_RD   = 5,
    parameter int unsigned W_IMM  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              v_i,
    input  logic [W_INST-1:0] inst_i,
    input  logic [ADDR-1:0]   pc_i,
    input  logic              stall_i,
    output logic              stall_o,
    input  logic              branch_i,
    input  logic              wb_i,
    input  logic [W_RD-1:0]   wb_r_i,
    input  logic [W_OPR-1:0]  wb_data_i,
    output logic              v_o,
    output logic [ADDR-1:0]   pc_o,
    output logic [W_OPC-1:0]  opecode_o,
    output logic [W_OPR-1:0]  opr0_o,
    output logic [W_OPR-1:0]  opr1_o,
    output logic              immf_o,
    output logic              immsign_o,
    output logic [W_IMM-1:0]  imm_o,
    output logic              stf_o,
    output logic              wb_o,
    output logic [W_RD-1:0]   wb_r_o
);

    localparam int unsigned N_REGS = 1 << W_RD;

    logic [W_OPC-1:0] opc;
    logic             immf;
    logic [W_RD-1:0]  ra;
    logic [W_RD-1:0]  rb;
    logic [W_IMM-1:0] imm;
    logic             immsign;
    logic             stf;
    logic             writes;
    logic [W_OPR-1:0] rd_a;
    logic [W_OPR-1:0] rd_b;
    logic             hazard;

    logic [W_OPR-1:0] regs [N_REGS];

    // Instruction fields; imm overlaps rB
    assign opc  = inst_i[31:25];
    assign immf = inst_i[24];
    assign ra   = inst_i[23:19];
    assign rb   = inst_i[18:14];
    assign imm  = inst_i[15:0];

    // Opcode decode: sign-extend select, store flag, rA write-back
    always_comb begin
        immsign = (opc[4:3] != 2'b10);
        stf     = (opc == W_OPC'(25));
        writes  = opc inside {[W_OPC'(0):W_OPC'(3)], [W_OPC'(5):W_OPC'(10)],
                              W_OPC'(12), W_OPC'(13), [W_OPC'(16):W_OPC'(19)],
                              [W_OPC'(22):W_OPC'(24)]};
    end

    // Register read with same-cycle write-back bypass
    always_comb begin
        rd_a = regs[ra];
        rd_b = regs[rb];
        if (wb_i && (wb_r_i == ra)) rd_a = wb_data_i;
        if (wb_i && (wb_r_i == rb)) rd_b = wb_data_i;
    end

    // Producer in execute has not registered its result yet; rB only counts without immediate
    assign hazard  = v_i && v_o && wb_o &&
                     ((ra == wb_r_o) || (!immf && (rb == wb_r_o)));
    assign stall_o = stall_i | hazard;

    // Register file; writes proceed regardless of stall, branch or hazard
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(N_REGS); i++) regs[i] <= '0;
        end else if (wb_i) begin
            regs[wb_r_i] <= wb_data_i;
        end
    end

    // Bundle register: stall holds, branch/hazard insert a bubble, else load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_o       <= 1'b0;
            pc_o      <= '0;
            opecode_o <= '0;
            opr0_o    <= '0;
            opr1_o    <= '0;
            immf_o    <= 1'b0;
            immsign_o <= 1'b0;
            imm_o     <= '0;
            stf_o     <= 1'b0;
            wb_o      <= 1'b0;
            wb_r_o    <= '0;
        end else if (stall_i) begin
            v_o <= v_o;
        end else if (branch_i || hazard) begin
            v_o <= 1'b0;
        end else begin
            v_o       <= v_i;
            pc_o      <= pc_i;
            opecode_o <= opc;
            opr0_o    <= rd_a;
            opr1_o    <= rd_b;
            immf_o    <= immf;
            immsign_o <= immsign;
            imm_o     <= imm;
            stf_o     <= stf;
            wb_o      <= writes;
            wb_r_o    <= ra;
        end
    end

endmodule

// File: tb/tb_decode_instruction.sv
// Testbench for decode_instruction: directed scenarios plus randomized
// traffic against a behavioural model of the decode stage.
module tb_decode_instruction;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        v_i = 1'b0;
    logic [31:0] inst_i = '0;
    logic [31:0] pc_i = '0;
    logic        stall_i = 1'b0;
    logic        stall_o;
    logic        branch_i = 1'b0;
    logic        wb_i = 1'b0;
    logic [4:0]  wb_r_i = '0;
    logic [31:0] wb_data_i = '0;
    logic        v_o;
    logic [31:0] pc_o;
    logic [6:0]  opecode_o;
    logic [31:0] opr0_o;
    logic [31:0] opr1_o;
    logic        immf_o;
    logic        immsign_o;
    logic [15:0] imm_o;
    logic        stf_o;
    logic        wb_o;
    logic [4:0]  wb_r_o;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    logic [31:0] m_regs [32];
    bit          m_v, m_known, m_immf, m_immsign, m_stf, m_wb;
    logic [31:0] m_pc, m_opr0, m_opr1;
    logic [6:0]  m_opc;
    logic [15:0] m_imm;
    logic [4:0]  m_wbr;

    decode_instruction dut (
        .clk(clk), .reset(reset), .v_i(v_i), .inst_i(inst_i), .pc_i(pc_i),
        .stall_i(stall_i), .stall_o(stall_o), .branch_i(branch_i),
        .wb_i(wb_i), .wb_r_i(wb_r_i), .wb_data_i(wb_data_i),
        .v_o(v_o), .pc_o(pc_o), .opecode_o(opecode_o), .opr0_o(opr0_o),
        .opr1_o(opr1_o), .immf_o(immf_o), .immsign_o(immsign_o), .imm_o(imm_o),
        .stf_o(stf_o), .wb_o(wb_o), .wb_r_o(wb_r_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(int op, bit immf, int ra, int rb, int imm);
        return 32'(op * 33554432 + int'(immf) * 16777216 + ra * 524288 +
                   (immf ? (imm % 65536) : rb * 16384));
    endfunction

    function automatic bit op_writes(int op);
        return (op <= 3) || (op >= 5 && op <= 10) || op == 12 || op == 13 ||
               (op >= 16 && op <= 19) || (op >= 22 && op <= 24);
    endfunction

    function automatic logic [31:0] m_read(int r);
        if (wb_i && int'(wb_r_i) == r) return wb_data_i;
        return m_regs[r];
    endfunction

    function automatic bit m_hazard();
        int  ra = int'(inst_i / 524288) % 32;
        int  rb = int'(inst_i / 16384) % 32;
        bit  uses_b = ((inst_i / 16777216) % 2) == 0;
        return v_i && m_v && m_wb && (ra == int'(m_wbr) || (uses_b && rb == int'(m_wbr)));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_v = 0; m_known = 1; m_immf = 0; m_immsign = 0; m_stf = 0; m_wb = 0;
        m_pc = '0; m_opr0 = '0; m_opr1 = '0; m_opc = '0; m_imm = '0; m_wbr = '0;
    endtask

    // Advance the model by one clock edge using the current inputs
    task automatic model_edge();
        int op = int'(inst_i / 33554432);
        int ra = int'(inst_i / 524288) % 32;
        int rb = int'(inst_i / 16384) % 32;
        bit haz = m_hazard();
        if (stall_i) begin
        end else if (branch_i || haz) begin
            m_v = 0;
            m_known = 0;
        end else begin
            m_v = v_i; m_known = 1;
            m_pc = pc_i;
            m_opc = 7'(op);
            m_opr0 = m_read(ra);
            m_opr1 = m_read(rb);
            m_immf = ((inst_i / 16777216) % 2) == 1;
            m_immsign = ((op / 8) % 4) != 2;
            m_imm = 16'(inst_i % 65536);
            m_stf = (op == 25);
            m_wb = op_writes(op);
            m_wbr = 5'(ra);
        end
        if (wb_i) m_regs[wb_r_i] = wb_data_i;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (v_o !== 1'b0) begin n_err++; $display("FAIL reset_v_o got %0b want 0", v_o); end
        n_vec++; if (wb_o !== 1'b0) begin n_err++; $display("FAIL reset_wb_o got %0b want 0", wb_o); end
        n_vec++; if (pc_o !== 32'h0) begin n_err++; $display("FAIL reset_pc_o got %h want 0", pc_o); end
        n_vec++; if (opr0_o !== 32'h0) begin n_err++; $display("FAIL reset_opr0 got %h want 0", opr0_o); end
        reset = 1'b1;
    endtask

    task automatic test_basic_add();
        wb_i = 1; wb_r_i = 4; wb_data_i = 7; cycle();
        wb_r_i = 3; wb_data_i = 5; cycle();
        wb_i = 0; v_i = 1; inst_i = mk(0, 0, 3, 4, 0); pc_i = 32'h100; cycle();
        n_vec++; if (v_o !== 1'b1) begin n_err++; $display("FAIL add_v_o got %0b want 1", v_o); end
        n_vec++; if (opecode_o !== 7'd0) begin n_err++; $display("FAIL add_opc got %0d want 0", opecode_o); end
        n_vec++; if (opr0_o !== 32'd5) begin n_err++; $display("FAIL add_opr0 got %0d want 5", opr0_o); end
        n_vec++; if (opr1_o !== 32'd7) begin n_err++; $display("FAIL add_opr1 got %0d want 7", opr1_o); end
        n_vec++; if (wb_o !== 1'b1 || wb_r_o !== 5'd3) begin n_err++; $display("FAIL add_wb got %0b/%0d want 1/3", wb_o, wb_r_o); end
    endtask

    task automatic test_hazard();
        inst_i = mk(0, 0, 1, 2, 0); pc_i = 32'h200; cycle();
        inst_i = mk(1, 0, 5, 1, 0); pc_i = 32'h204; #1;
        n_vec++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL haz_stall got %0b want 1", stall_o); end
        cycle();
        n_vec++; if (v_o !== 1'b0) begin n_err++; $display("FAIL haz_bubble got %0b want 0", v_o); end
        wb_i = 1; wb_r_i = 1; wb_data_i = 32'h1234_5678; #1;
        n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL haz_release got %0b want 0", stall_o); end
        cycle();
        wb_i = 0;
        n_vec++; if (v_o !== 1'b1 || opecode_o !== 7'd1) begin n_err++; $display("FAIL haz_issue got %0b/%0d want 1/1", v_o, opecode_o); end
        n_vec++; if (opr1_o !== 32'h1234_5678) begin n_err++; $display("FAIL haz_bypass got %h want 12345678", opr1_o); end
    endtask

    task automatic test_imm();
        inst_i = mk(16, 1, 2, 0, 16'h8001); pc_i = 32'h300; cycle();
        n_vec++; if (immsign_o !== 1'b0) begin n_err++; $display("FAIL imm_and_sign got %0b want 0", immsign_o); end
        n_vec++; if (imm_o !== 16'h8001 || immf_o !== 1'b1) begin n_err++; $display("FAIL imm_field got %h/%0b want 8001/1", imm_o, immf_o); end
        // rB bits of this word equal 2 (the AND's destination) but immf hides them
        inst_i = mk(0, 1, 7, 0, 16'h8001); pc_i = 32'h304; #1;
        n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL imm_no_haz got %0b want 0", stall_o); end
        cycle();
        n_vec++; if (v_o !== 1'b1 || immsign_o !== 1'b1) begin n_err++; $display("FAIL imm_add_sign got %0b/%0b want 1/1", v_o, immsign_o); end
    endtask

    task automatic test_branch();
        inst_i = mk(0, 0, 8, 0, 0); pc_i = 32'h400; cycle();
        inst_i = mk(1, 0, 9, 8, 0); pc_i = 32'h404; branch_i = 1; #1;
        n_vec++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL br_stall got %0b want 1", stall_o); end
        cycle();
        branch_i = 0;
        n_vec++; if (v_o !== 1'b0) begin n_err++; $display("FAIL br_flush got %0b want 0", v_o); end
        inst_i = mk(0, 0, 10, 11, 0); pc_i = 32'h500; #1;
        n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL br_after_stall got %0b want 0", stall_o); end
        cycle();
        n_vec++; if (v_o !== 1'b1 || wb_r_o !== 5'd10) begin n_err++; $display("FAIL br_next got %0b/%0d want 1/10", v_o, wb_r_o); end
    endtask

    task automatic test_stall();
        stall_i = 1; inst_i = mk(16, 0, 12, 0, 0); pc_i = 32'h600;
        wb_i = 1; wb_r_i = 9; wb_data_i = 32'hCAFE_F00D;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL st_stall_o got %0b want 1", stall_o); end
            cycle();
            wb_i = 0;
            n_vec++; if (v_o !== 1'b1 || pc_o !== 32'h500 || wb_r_o !== 5'd10)
                begin n_err++; $display("FAIL st_hold got %0b/%h/%0d want 1/500/10", v_o, pc_o, wb_r_o); end
        end
        stall_i = 0; inst_i = mk(0, 1, 9, 0, 0); pc_i = 32'h700; cycle();
        n_vec++; if (opr0_o !== 32'hCAFE_F00D || pc_o !== 32'h700) begin n_err++; $display("FAIL st_r9 got %h/%h want cafef00d/700", opr0_o, pc_o); end
    endtask

    task automatic test_no_writeback();
        int ops [6] = '{4, 25, 28, 29, 30, 31};
        foreach (ops[k]) begin
            inst_i = mk(ops[k], 1, 20, 0, 0); pc_i = 32'(32'h800 + k * 4); cycle();
            n_vec++; if (wb_o !== 1'b0) begin n_err++; $display("FAIL nowb_%0d got %0b want 0", ops[k], wb_o); end
            n_vec++; if (stf_o !== (ops[k] == 25)) begin n_err++; $display("FAIL stf_%0d got %0b want %0b", ops[k], stf_o, ops[k] == 25); end
        end
    endtask

    task automatic test_reset_midstream();
        stall_i = 1; v_i = 1; cycle();
        reset = 1'b0;
        model_reset();
        #2;
        n_vec++; if (v_o !== 1'b0 || wb_o !== 1'b0) begin n_err++; $display("FAIL rst_mid got %0b/%0b want 0/0", v_o, wb_o); end
        reset = 1'b1; stall_i = 0;
        for (int i = 0; i < 32; i++) begin
            inst_i = mk(30, 0, i, 31 - i, 0); cycle();
            n_vec++; if (opr0_o !== 32'h0 || opr1_o !== 32'h0)
                begin n_err++; $display("FAIL rst_reg_%0d got %h/%h want 0/0", i, opr0_o, opr1_o); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 7) != 0) w[31:30] = 2'b00;
            w[23:19] = 5'($urandom_range(0, 7));
            w[18:14] = 5'($urandom_range(0, 7));
            inst_i = w;
            v_i = ($urandom_range(0, 9) != 0);
            pc_i = $urandom;
            stall_i = ($urandom_range(0, 7) == 0);
            branch_i = ($urandom_range(0, 11) == 0);
            wb_i = 1'($urandom);
            wb_r_i = 5'($urandom_range(0, 7));
            wb_data_i = $urandom;
            #1;
            n_vec++; if (stall_o !== (stall_i | m_hazard())) begin n_err++; $display("FAIL rnd_stall_o[%0d] got %0b want %0b", n, stall_o, stall_i | m_hazard()); end
            cycle();
            n_vec++; if (v_o !== m_v) begin n_err++; $display("FAIL rnd_v_o[%0d] got %0b want %0b", n, v_o, m_v); end
            if (m_known) begin
                n_vec++; if (pc_o !== m_pc) begin n_err++; $display("FAIL rnd_pc[%0d] got %h want %h", n, pc_o, m_pc); end
                n_vec++; if (opecode_o !== m_opc) begin n_err++; $display("FAIL rnd_opc[%0d] got %0d want %0d", n, opecode_o, m_opc); end
                n_vec++; if (opr0_o !== m_opr0) begin n_err++; $display("FAIL rnd_opr0[%0d] got %h want %h", n, opr0_o, m_opr0); end
                if (!m_immf) begin
                    n_vec++; if (opr1_o !== m_opr1) begin n_err++; $display("FAIL rnd_opr1[%0d] got %h want %h", n, opr1_o, m_opr1); end
                end
                n_vec++; if (immf_o !== m_immf) begin n_err++; $display("FAIL rnd_immf[%0d] got %0b want %0b", n, immf_o, m_immf); end
                n_vec++; if (immsign_o !== m_immsign) begin n_err++; $display("FAIL rnd_immsign[%0d] got %0b want %0b", n, immsign_o, m_immsign); end
                n_vec++; if (imm_o !== m_imm) begin n_err++; $display("FAIL rnd_imm[%0d] got %h want %h", n, imm_o, m_imm); end
                n_vec++; if (stf_o !== m_stf) begin n_err++; $display("FAIL rnd_stf[%0d] got %0b want %0b", n, stf_o, m_stf); end
                n_vec++; if (wb_o !== m_wb) begin n_err++; $display("FAIL rnd_wb[%0d] got %0b want %0b", n, wb_o, m_wb); end
                n_vec++; if (wb_r_o !== m_wbr) begin n_err++; $display("FAIL rnd_wbr[%0d] got %0d want %0d", n, wb_r_o, m_wbr); end
            end
        end
        stall_i = 0; branch_i = 0; wb_i = 0; v_i = 0;
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_hazard();
        test_imm();
        test_branch();
        test_stall();
        test_no_writeback();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decode_instruction.md
# decode_instruction

Decode and register-read stage sitting directly upstream of the execute stage. It accepts one fetched instruction per cycle, splits it into fields, reads two operands from an internal 32 x 32-bit register file (written back from the execute stage's registered result), and detects the one-cycle result-use hazard. It then presents a registered instruction bundle to execute, with valid/stall/flush handling.

## Interface
- ADDR, 32, PC width
- W_INST, 32, instruction width
- W_OPC, 7, opcode width
- W_OPR, 32, operand/register width
- W_RD, 5, register index width (32 registers)
- W_IMM, 16, immediate width

- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- v_i  in  1  fetched instruction valid
- inst_i  in  W_INST  instruction word
- pc_i  in  ADDR  PC of inst_i
- stall_i  in  1  stall from execute; freezes this stage
- stall_o  out  1  stall to fetch; = stall_i | hazard
- branch_i  in  1  taken branch from execute; flushes this stage
- wb_i, wb_r_i, wb_data_i  in  1/W_RD/W_OPR  write-back port (execute wb_o, wb_r_o, result_o)
- v_o  out  1  bundle valid
- pc_o  out  ADDR  PC of bundle
- opecode_o  out  W_OPC  opcode
- opr0_o, opr1_o  out  W_OPR  operand A / operand B register values
- immf_o, immsign_o  out  1  immediate select / sign-extend select
- imm_o  out  W_IMM  immediate
- stf_o  out  1  store flag
- wb_o  out  1  instruction writes rA
- wb_r_o  out  W_RD  destination register (= rA)

## Operation
- Fields: opcode = inst[31:25], immf = inst[24], rA = inst[23:19], rB = inst[18:14], imm = inst[15:0] (imm overlaps rB; rB ignored when immf=1).
- immsign = (opcode[4:3] != 2'b10): logic ops (16-19) and SETL/SETH (22,23) zero-extend.
- stf = (opcode == 25).
- wb = 1 for opcodes 0-3, 5-10, 12, 13, 16-19, 22-24; 0 otherwise (CMP 4, ST 25, J/JA 28/29, NOP 30, HLT 31, undefined).
- Sources: rA is always read; rB is read only when immf=0.
- Register read: combinational read of rA/rB, with bypass. If wb_i and wb_r_i equals the index, wb_data_i is used instead of the array value.
- Register write: on the clock edge when wb_i=1, regs[wb_r_i] <= wb_data_i. Writes occur even during stall_i, branch_i or hazard. r0 is an ordinary register.
- Hazard: asserted when v_i & v_o & wb_o and the decoding instruction uses a source equal to wb_r_o. The result is not available until execute registers it.
  - On hazard, the bundle is held in fetch (stall_o=1) and a bubble is inserted (v_o<=0 next cycle).
  - The following cycle, the bypass supplies the value.
- Priority per clock edge, highest first:
  1. stall_i: all output registers hold.
  2. branch_i: v_o<=0; the fetched instruction is discarded; hazard is ignored.
  3. hazard: v_o<=0; other fields don't-care.
  4. Otherwise: all output registers load the decoded instruction; v_o<=v_i.
- Output fields load even when v_i=0; downstream qualifies them with v_o.

## Timing
- Latency 1 cycle from inst_i to outputs.
- stall_o is combinational.
- Reset (async, low): all output registers are 0, including v_o=0 and wb_o=0. All 32 registers are cleared to 0. Reset mid-stall drops the bundle.
- Throughput 1 instruction/cycle without hazards.
- A dependent instruction immediately after a producer costs exactly 1 bubble.
- A dependency two or more instructions back costs no bubble, thanks to the bypass and the write-back.
- A load followed by a dependent instruction costs 1 bubble. The loaded data arrives through wb_data_i the next cycle.

## Test plan
- Reset, then v_i=1, inst ADD rA=3 rB=4, with r4 written to 7 and r3 written to 5 via the wb port two cycles earlier -> next cycle v_o=1, opecode_o=0, opr0_o=5, opr1_o=7, wb_o=1, wb_r_o=3.
- ADD r1,r2 followed by SUB r5,r1 back-to-back -> stall_o=1 for one cycle, one v_o=0 bubble. When SUB issues, opr1_o equals wb_data_i as driven that cycle (bypass).
- immf=1, imm=0x8001: AND -> immsign_o=0; ADD -> immsign_o=1. rB bits ignored for the hazard check.
- branch_i=1 while a valid instruction is in decode and a hazard is pending -> v_o=0 next cycle, stall_o still reflects hazard only that cycle, no further bubble.
- stall_i=1 for 3 cycles with v_o=1 -> outputs unchanged. A wb write to r9 during the stall is visible on a later read of r9.
- CMP, ST, J, NOP, HLT decode -> wb_o=0. ST -> stf_o=1. Assert reset mid-stream -> v_o=0 and every register reads 0.
